// File: rtl/z80fi_pkg.sv
// Shared Z80 formal-interface definitions: spec-signal layout, block-move opcodes,
// sequencer state encoding and the block-move flag helper.
package z80fi_pkg;

  localparam int unsigned SPEC_SIG_W = 16;

  // One bit per architectural resource a spec may claim to update or access.
  typedef struct packed {
    logic [4:0] rsvd;
    logic       mem_wr;
    logic       mem_rd;
    logic       sp;
    logic       iy;
    logic       ix;
    logic       hl;
    logic       de;
    logic       bc;
    logic       f;
    logic       a;
    logic       ip;
  } spec_sig_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } ld_blk_state_t;

  localparam logic [7:0] OP_PREFIX_ED = 8'hED;
  localparam logic [7:0] OP_LDI       = 8'hA0;
  localparam logic [7:0] OP_LDD       = 8'hA8;
  localparam logic [7:0] OP_LDIR      = 8'hB0;
  localparam logic [7:0] OP_LDDR      = 8'hB8;

  // Undocumented bits 5/3 come from A plus the transferred byte.
  function automatic logic [7:0] ld_blk_flags(input logic [7:0] f_in,
                                              input logic [7:0] a_in,
                                              input logic [7:0] rdata,
                                              input logic       bc_nz);
    logic [7:0] t;
    t = a_in + rdata;
    return {f_in[7], f_in[6], t[1], 1'b0, t[3], bc_nz, 1'b0, f_in[0]};
  endfunction

endpackage

// File: rtl/z80fi_ld_blk_calc.sv
// Combinational decode and result calculation for LDI/LDD/LDIR/LDDR.
// All result outputs are zero whenever the instruction is not matched.
module z80fi_ld_blk_calc
  import z80fi_pkg::*;
#(
  parameter bit ENABLE_REPEAT = 1'b1
) (
  input  logic                  i_valid,
  input  logic [15:0]           i_insn,
  input  logic [2:0]            i_insn_len,
  input  logic [15:0]           i_ip,
  input  logic [15:0]           i_hl,
  input  logic [15:0]           i_de,
  input  logic [15:0]           i_bc,
  input  logic [7:0]            i_a,
  input  logic [7:0]            i_f,
  input  logic [7:0]            i_rdata,
  output logic                  o_match,
  output logic                  o_repeat,
  output logic                  o_bc_nz,
  output logic [SPEC_SIG_W-1:0] o_signals,
  output logic [15:0]           o_ip,
  output logic [15:0]           o_hl,
  output logic [15:0]           o_de,
  output logic [15:0]           o_bc,
  output logic [7:0]            o_f,
  output logic [15:0]           o_raddr,
  output logic [15:0]           o_waddr,
  output logic [7:0]            o_wdata
);

  logic [7:0]  w_op;
  logic        w_is_single;
  logic        w_is_repeat;
  logic        w_decrement;
  logic [15:0] w_bc_dec;
  logic        w_bc_nz;
  spec_sig_t   w_sig;

  assign w_op        = i_insn[15:8];
  assign w_is_single = (w_op == OP_LDI) || (w_op == OP_LDD);
  assign w_is_repeat = ENABLE_REPEAT && ((w_op == OP_LDIR) || (w_op == OP_LDDR));
  assign w_decrement = (w_op == OP_LDD) || (w_op == OP_LDDR);
  assign w_bc_dec    = i_bc - 16'd1;
  assign w_bc_nz     = (w_bc_dec != 16'd0);

  always_comb begin
    w_sig        = '0;
    w_sig.ip     = 1'b1;
    w_sig.hl     = 1'b1;
    w_sig.de     = 1'b1;
    w_sig.bc     = 1'b1;
    w_sig.f      = 1'b1;
    w_sig.mem_rd = 1'b1;
    w_sig.mem_wr = 1'b1;
  end

  always_comb begin
    o_match   = 1'b0;
    o_repeat  = 1'b0;
    o_bc_nz   = 1'b0;
    o_signals = '0;
    o_ip      = '0;
    o_hl      = '0;
    o_de      = '0;
    o_bc      = '0;
    o_f       = '0;
    o_raddr   = '0;
    o_waddr   = '0;
    o_wdata   = '0;
    if (i_valid && (i_insn_len == 3'd2) && (i_insn[7:0] == OP_PREFIX_ED) &&
        (w_is_single || w_is_repeat)) begin
      o_match   = 1'b1;
      o_repeat  = w_is_repeat;
      o_bc_nz   = w_bc_nz;
      o_signals = SPEC_SIG_W'(w_sig);
      o_hl      = w_decrement ? (i_hl - 16'd1) : (i_hl + 16'd1);
      o_de      = w_decrement ? (i_de - 16'd1) : (i_de + 16'd1);
      o_bc      = w_bc_dec;
      // A repeat that still has work to do re-executes the same instruction.
      o_ip      = (w_is_repeat && w_bc_nz) ? i_ip : (i_ip + 16'd2);
      o_f       = ld_blk_flags(i_f, i_a, i_rdata, w_bc_nz);
      o_raddr   = i_hl;
      o_waddr   = i_de;
      o_wdata   = i_rdata;
    end
  end

endmodule

// File: rtl/z80fi_insn_spec_ld_blk.sv
// Block-move instruction spec (LDI/LDD/LDIR/LDDR) with a sequencer that tracks
// repeat sequences across retirements and flags broken register continuity.
module z80fi_insn_spec_ld_blk
  import z80fi_pkg::*;
#(
  parameter int unsigned ITER_W           = 16,
  parameter bit          ENABLE_REPEAT    = 1'b1,
  parameter bit          CHECK_CONTINUITY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  z80fi_valid,
  input  logic [31:0]           z80fi_insn,
  input  logic [2:0]            z80fi_insn_len,
  input  logic [15:0]           z80fi_reg_ip_in,
  input  logic [15:0]           z80fi_reg_hl_in,
  input  logic [15:0]           z80fi_reg_de_in,
  input  logic [15:0]           z80fi_reg_bc_in,
  input  logic [7:0]            z80fi_reg_a_in,
  input  logic [7:0]            z80fi_reg_f_in,
  input  logic [7:0]            z80fi_mem_rdata,
  output logic                  spec_valid,
  output logic [SPEC_SIG_W-1:0] spec_signals,
  output logic [15:0]           spec_reg_ip_out,
  output logic [15:0]           spec_reg_hl_out,
  output logic [15:0]           spec_reg_de_out,
  output logic [15:0]           spec_reg_bc_out,
  output logic [15:0]           spec_mem_raddr,
  output logic [15:0]           spec_mem_waddr,
  output logic [7:0]            spec_reg_f_out,
  output logic [7:0]            spec_mem_wdata,
  output logic                  seq_active,
  output logic [ITER_W-1:0]     iter_count,
  output logic                  seq_err
);

  ld_blk_state_t     r_state;
  logic [ITER_W-1:0] r_iter_count;
  logic              r_seq_err;
  logic [15:0]       r_exp_hl;
  logic [15:0]       r_exp_de;
  logic [15:0]       r_exp_bc;
  logic [15:0]       r_exp_ip;
  logic [7:0]        r_exp_op;

  logic              w_repeat;
  logic              w_bc_nz;
  logic [7:0]        w_op;
  logic              w_regs_match;
  logic              w_unused;

  assign w_op     = z80fi_insn[15:8];
  assign w_unused = ^z80fi_insn[31:16];

  z80fi_ld_blk_calc #(
    .ENABLE_REPEAT (ENABLE_REPEAT)
  ) u_calc (
    .i_valid    (z80fi_valid),
    .i_insn     (z80fi_insn[15:0]),
    .i_insn_len (z80fi_insn_len),
    .i_ip       (z80fi_reg_ip_in),
    .i_hl       (z80fi_reg_hl_in),
    .i_de       (z80fi_reg_de_in),
    .i_bc       (z80fi_reg_bc_in),
    .i_a        (z80fi_reg_a_in),
    .i_f        (z80fi_reg_f_in),
    .i_rdata    (z80fi_mem_rdata),
    .o_match    (spec_valid),
    .o_repeat   (w_repeat),
    .o_bc_nz    (w_bc_nz),
    .o_signals  (spec_signals),
    .o_ip       (spec_reg_ip_out),
    .o_hl       (spec_reg_hl_out),
    .o_de       (spec_reg_de_out),
    .o_bc       (spec_reg_bc_out),
    .o_f        (spec_reg_f_out),
    .o_raddr    (spec_mem_raddr),
    .o_waddr    (spec_mem_waddr),
    .o_wdata    (spec_mem_wdata)
  );

  assign w_regs_match = (z80fi_reg_hl_in == r_exp_hl) && (z80fi_reg_de_in == r_exp_de) &&
                        (z80fi_reg_bc_in == r_exp_bc) && (z80fi_reg_ip_in == r_exp_ip);

  // Repeat-sequence tracker; only retirement cycles move it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_iter_count <= '0;
      r_seq_err    <= 1'b0;
      r_exp_hl     <= '0;
      r_exp_de     <= '0;
      r_exp_bc     <= '0;
      r_exp_ip     <= '0;
      r_exp_op     <= '0;
    end else if (z80fi_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (spec_valid && w_repeat) begin
            r_iter_count <= ITER_W'(1);
            if (w_bc_nz) begin
              r_state  <= ST_ACTIVE;
              r_exp_hl <= spec_reg_hl_out;
              r_exp_de <= spec_reg_de_out;
              r_exp_bc <= spec_reg_bc_out;
              r_exp_ip <= z80fi_reg_ip_in;
              r_exp_op <= w_op;
            end
          end
        end
        ST_ACTIVE: begin
          if (spec_valid && (w_op == r_exp_op)) begin
            if (CHECK_CONTINUITY && !w_regs_match) begin
              r_seq_err <= 1'b1;
            end
            if (r_iter_count != {ITER_W{1'b1}}) begin
              r_iter_count <= r_iter_count + ITER_W'(1);
            end
            if (w_bc_nz) begin
              r_exp_hl <= spec_reg_hl_out;
              r_exp_de <= spec_reg_de_out;
              r_exp_bc <= spec_reg_bc_out;
              r_exp_ip <= z80fi_reg_ip_in;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            // Anything else retiring mid-sequence means it was interrupted.
            if (CHECK_CONTINUITY) begin
              r_seq_err <= 1'b1;
            end
            r_state      <= ST_IDLE;
            r_iter_count <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign seq_active = (r_state == ST_ACTIVE);
  assign iter_count = r_iter_count;
  assign seq_err    = r_seq_err;

endmodule

// File: tb/tb_z80fi_insn_spec_ld_blk.sv
// Scoreboard bench for the block-move spec: stimulus queues expected results,
// a monitor checks them on every retirement.
module tb_z80fi_insn_spec_ld_blk;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] ip_in, hl_in, de_in, bc_in;
  logic [7:0]  a_in, f_in, rdata;

  logic        spec_valid, seq_active, seq_err;
  logic [15:0] spec_signals, ip_out, hl_out, de_out, bc_out, raddr, waddr, iter_count;
  logic [7:0]  f_out, wdata;

  logic        nr_valid, nr_active, nr_err;
  logic [15:0] nr_signals, nr_ip, nr_hl, nr_de, nr_bc, nr_raddr, nr_waddr, nr_iter;
  logic [7:0]  nr_f, nr_wdata;

  always #5 clk = ~clk;

  z80fi_insn_spec_ld_blk dut (
    .clk(clk), .reset_n(reset_n), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
    .z80fi_insn_len(z80fi_insn_len), .z80fi_reg_ip_in(ip_in), .z80fi_reg_hl_in(hl_in),
    .z80fi_reg_de_in(de_in), .z80fi_reg_bc_in(bc_in), .z80fi_reg_a_in(a_in),
    .z80fi_reg_f_in(f_in), .z80fi_mem_rdata(rdata), .spec_valid(spec_valid),
    .spec_signals(spec_signals), .spec_reg_ip_out(ip_out), .spec_reg_hl_out(hl_out),
    .spec_reg_de_out(de_out), .spec_reg_bc_out(bc_out), .spec_mem_raddr(raddr),
    .spec_mem_waddr(waddr), .spec_reg_f_out(f_out), .spec_mem_wdata(wdata),
    .seq_active(seq_active), .iter_count(iter_count), .seq_err(seq_err)
  );

  z80fi_insn_spec_ld_blk #(.ENABLE_REPEAT(1'b0)) dut_norep (
    .clk(clk), .reset_n(reset_n), .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn),
    .z80fi_insn_len(z80fi_insn_len), .z80fi_reg_ip_in(ip_in), .z80fi_reg_hl_in(hl_in),
    .z80fi_reg_de_in(de_in), .z80fi_reg_bc_in(bc_in), .z80fi_reg_a_in(a_in),
    .z80fi_reg_f_in(f_in), .z80fi_mem_rdata(rdata), .spec_valid(nr_valid),
    .spec_signals(nr_signals), .spec_reg_ip_out(nr_ip), .spec_reg_hl_out(nr_hl),
    .spec_reg_de_out(nr_de), .spec_reg_bc_out(nr_bc), .spec_mem_raddr(nr_raddr),
    .spec_mem_waddr(nr_waddr), .spec_reg_f_out(nr_f), .spec_mem_wdata(nr_wdata),
    .seq_active(nr_active), .iter_count(nr_iter), .seq_err(nr_err)
  );

  typedef struct {
    logic        valid;
    logic [15:0] ip, hl, de, bc, raddr, waddr;
    logic [7:0]  f, wdata;
    logic        nr_valid;
    logic        act;
    logic [15:0] iter;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [15:0] ip, hl, de, bc, ra, wa,
                              input logic [7:0] f, wd, input logic nr, act,
                              input logic [15:0] iter, input logic err);
    exp_t e;
    e.valid = v;  e.ip = ip; e.hl = hl; e.de = de; e.bc = bc; e.raddr = ra; e.waddr = wa;
    e.f = f; e.wdata = wd; e.nr_valid = nr; e.act = act; e.iter = iter; e.err = err;
    return e;
  endfunction

  task automatic retire(input logic [7:0] op, input logic [2:0] len,
                        input logic [15:0] ip, hl, de, bc,
                        input logic [7:0] a, f, rd, input exp_t e);
    @(posedge clk); #1;
    z80fi_insn = {16'h0000, op, 8'hED};
    z80fi_insn_len = len;
    ip_in = ip; hl_in = hl; de_in = de; bc_in = bc;
    a_in = a; f_in = f; rdata = rd;
    sb_q.push_back(e);
    z80fi_valid = 1'b1;
    @(posedge clk); #1;
    z80fi_valid = 1'b0;
  endtask

  // Monitor: combinational spec at mid-cycle, sequencer state after the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (z80fi_valid === 1'b1) begin
        exp_t e;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: got retire expected none at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          check("spec_valid", 32'(spec_valid), 32'(e.valid));
          check("spec_signals", 32'(spec_signals), e.valid ? 32'h063D : 32'h0);
          check("ip_out", 32'(ip_out), 32'(e.ip));
          check("hl_out", 32'(hl_out), 32'(e.hl));
          check("de_out", 32'(de_out), 32'(e.de));
          check("bc_out", 32'(bc_out), 32'(e.bc));
          check("f_out", 32'(f_out), 32'(e.f));
          check("raddr", 32'(raddr), 32'(e.raddr));
          check("waddr", 32'(waddr), 32'(e.waddr));
          check("wdata", 32'(wdata), 32'(e.wdata));
          check("norep_valid", 32'(nr_valid), 32'(e.nr_valid));
          @(posedge clk); #2;
          check("seq_active", 32'(seq_active), 32'(e.act));
          check("iter_count", 32'(iter_count), 32'(e.iter));
          check("seq_err", 32'(seq_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    z80fi_valid = 1'b0;
    z80fi_insn = '0; z80fi_insn_len = '0;
    ip_in = '0; hl_in = '0; de_in = '0; bc_in = '0; a_in = '0; f_in = '0; rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_seq_active", 32'(seq_active), 32'h0);
    check("rst_iter_count", 32'(iter_count), 32'h0);
    check("rst_seq_err", 32'(seq_err), 32'h0);
    check("idle_spec_valid", 32'(spec_valid), 32'h0);
    check("idle_hl_out", 32'(hl_out), 32'h0);
    reset_n = 1'b1;

    // LDI basic
    retire(8'hA0, 3'd2, 16'h0100, 16'h1000, 16'h2000, 16'h0003, 8'h00, 8'hC1, 8'h5A,
           mk(1, 16'h0102, 16'h1001, 16'h2001, 16'h0002, 16'h1000, 16'h2000, 8'hED, 8'h5A, 1, 0, 0, 0));
    // LDDR, BC=3, consistent registers
    retire(8'hB8, 3'd2, 16'h0200, 16'h3005, 16'h4005, 16'h0003, 8'h10, 8'h00, 8'h33,
           mk(1, 16'h0200, 16'h3004, 16'h4004, 16'h0002, 16'h3005, 16'h4005, 8'h24, 8'h33, 0, 1, 1, 0));
    retire(8'hB8, 3'd2, 16'h0200, 16'h3004, 16'h4004, 16'h0002, 8'h10, 8'h00, 8'h33,
           mk(1, 16'h0200, 16'h3003, 16'h4003, 16'h0001, 16'h3004, 16'h4004, 8'h24, 8'h33, 0, 1, 2, 0));
    retire(8'hB8, 3'd2, 16'h0200, 16'h3003, 16'h4003, 16'h0001, 8'h10, 8'h00, 8'h33,
           mk(1, 16'h0202, 16'h3002, 16'h4002, 16'h0000, 16'h3003, 16'h4003, 8'h20, 8'h33, 0, 0, 3, 0));
    // LDIR, BC=2, second retire with HL off by one
    retire(8'hB0, 3'd2, 16'h0300, 16'h5000, 16'h6000, 16'h0002, 8'h00, 8'h00, 8'h00,
           mk(1, 16'h0300, 16'h5001, 16'h6001, 16'h0001, 16'h5000, 16'h6000, 8'h04, 8'h00, 0, 1, 1, 0));
    retire(8'hB0, 3'd2, 16'h0300, 16'h5002, 16'h6001, 16'h0001, 8'h00, 8'h00, 8'h00,
           mk(1, 16'h0302, 16'h5003, 16'h6002, 16'h0000, 16'h5002, 16'h6001, 8'h00, 8'h00, 0, 0, 2, 1));
    // LDIR BC=0 wraps, HL=FFFF increments to 0000
    retire(8'hB0, 3'd2, 16'h0400, 16'hFFFF, 16'h1234, 16'h0000, 8'h00, 8'h00, 8'h08,
           mk(1, 16'h0400, 16'h0000, 16'h1235, 16'hFFFF, 16'hFFFF, 16'h1234, 8'h0C, 8'h08, 0, 1, 1, 1));
    // Different instruction mid-sequence aborts it
    retire(8'hA0, 3'd2, 16'h0500, 16'h0010, 16'h0020, 16'h0001, 8'h00, 8'h01, 8'hFF,
           mk(1, 16'h0502, 16'h0011, 16'h0021, 16'h0000, 16'h0010, 16'h0020, 8'h29, 8'hFF, 1, 0, 0, 1));
    // Non-matching: ED A1, and ED A0 with wrong length
    retire(8'hA1, 3'd2, 16'h0600, 16'h1111, 16'h2222, 16'h0003, 8'h00, 8'h00, 8'h00,
           mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1));
    retire(8'hA0, 3'd3, 16'h0600, 16'h1111, 16'h2222, 16'h0003, 8'h00, 8'h00, 8'h00,
           mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1));

    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check("rst2_seq_err", 32'(seq_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // LDIR BC=1 from idle: single iteration
    retire(8'hB0, 3'd2, 16'h0700, 16'h0010, 16'h0020, 16'h0001, 8'h00, 8'h00, 8'h00,
           mk(1, 16'h0702, 16'h0011, 16'h0021, 16'h0000, 16'h0010, 16'h0020, 8'h00, 8'h00, 0, 0, 1, 0));
    retire(8'hB0, 3'd2, 16'h0600, 16'h7000, 16'h7100, 16'h0005, 8'h00, 8'h00, 8'h00,
           mk(1, 16'h0600, 16'h7001, 16'h7101, 16'h0004, 16'h7000, 16'h7100, 8'h04, 8'h00, 0, 1, 1, 0));

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    #3 reset_n = 1'b0;
    #1;
    check("midseq_rst_active", 32'(seq_active), 32'h0);
    check("midseq_rst_iter", 32'(iter_count), 32'h0);
    check("midseq_rst_err", 32'(seq_err), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
